instr_fetch_assembler: RTL and testbench
========================================

Name: instr_fetch_assembler

Overview:
- Parametrised front end for the instruction decoder.
- Prefetches the byte stream from memory into a DEPTH-entry FIFO and assembles complete instructions: optional 0xCB prefix, opcode, and 0/1/2 immediate bytes.
- Presents each instruction to the decoder as one bundle over a valid/ready handshake, so the decoder no longer has to wait on byte-by-byte memory acknowledges.
- Sits between the memory arbiter and instruction_decoder; a flush port lets jumps, calls and returns redirect the fetch PC.

Parameters:
- DEPTH, 4: prefetch FIFO entries; power of two, ≥2.
- ADDR_W, 16: fetch address width.
- IMM_FIRST_HIGH, 1: 1 = first immediate byte fetched is imm[15:8]; 0 = first byte is imm[7:0] (little-endian).
- RESET_PC, 16'h0000: fetch address after reset.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- fetch_req  out  1  memory read request
- fetch_addr  out  ADDR_W  byte address of the request
- fetch_ack  in  1  data valid; only meaningful while fetch_req=1
- fetch_data  in  8  returned byte
- flush  in  1  redirect the fetch stream
- flush_pc  in  ADDR_W  new fetch address
- instr_valid  out  1  bundle valid
- instr_ready  in  1  decoder accepts the bundle
- instr_opcode  out  8  opcode; the byte after 0xCB when prefixed
- instr_cb  out  1  CB-prefixed instruction
- instr_imm  out  16  immediate, zero-extended; 0 when len=0
- instr_len  out  2  number of immediate bytes (0..2)
- instr_pc  out  ADDR_W  address of the first byte (prefix if present)

Behaviour:
- Reset (asynchronous, nrst=0):
  - fetch_addr=RESET_PC, fetch_req=0.
  - FIFO empty.
  - State FETCH_OP.
  - All instr_* outputs 0.
  - fetch_req asserts on the first clk edge after release.
- Fetch engine:
  - fetch_req=1 whenever FIFO occupancy < DEPTH and not in a flush cycle.
  - fetch_req is held until fetch_ack. On ack, the byte is written to the FIFO and fetch_addr increments, wrapping modulo 2^ADDR_W.
  - One outstanding request only. The FIFO never overflows: req is gated on occupancy before push.
  - Push and pop in the same cycle leave occupancy unchanged.
- FIFO: no bypass. A byte acked in cycle t is poppable in cycle t+1.
- Assembler FSM (fetch_pkg::asm_state): FETCH_OP, FETCH_CB, FETCH_IMM, PRESENT. At most one byte is popped per cycle, only in the FETCH_* states and only when the FIFO is non-empty.
  - FETCH_OP, popping byte b:
    - Latch instr_pc.
    - If b=0xCB, go to FETCH_CB.
    - Otherwise latch the opcode and set len=imm_bytes(b). len=0 goes to PRESENT; len>0 goes to FETCH_IMM.
  - FETCH_CB: pop the opcode, set cb=1, len=0, go to PRESENT.
  - FETCH_IMM: pop bytes into imm per IMM_FIRST_HIGH. After the len-th byte, go to PRESENT.
  - PRESENT: instr_valid=1 and all bundle fields stable. Outputs are registered, so valid rises the cycle after the final pop. On instr_valid & instr_ready, go to FETCH_OP with instr_valid=0 next cycle; no pop in the handshake cycle.
- Minimum latency with the FIFO empty: 1-byte instruction, ack at t, valid at t+2.
- Flush (any state):
  - Next cycle: FIFO emptied, FSM to FETCH_OP, instr_valid=0, partial bundle discarded, fetch_addr=flush_pc.
  - fetch_req=0 during the flush cycle.
  - A fetch_ack in the flush cycle is discarded and does not increment fetch_addr.
  - Flush has priority over a simultaneous handshake: the bundle counts as not accepted.
- imm_bytes (shared package function):
  - 1 byte: 06 0E 16 1E 26 2E 36 3E 18 20 28 30 38 C6 CE D6 DE E6 EE F6 FE E0 F0 E8 F8.
  - 2 bytes: 01 11 21 31 08 C2 C3 C4 CA CC CD D2 D4 DA DC EA FA.
  - Everything else, including all CB-page opcodes: 0.
- Illegal opcodes are assembled as len=0; the decoder handles them.

Decomposition:
- New package fetch_pkg: asm_state enum, imm_bytes() function, CB_PREFIX=8'hCB constant.
- Sub-module fetch_fifo: parametrised DEPTH×8 synchronous FIFO with push, pop, clear, empty, full and count; asynchronous active-low reset.
- The assembler FSM and fetch engine live in the top module.

Test Plan:
- RESET_PC=0, memory returns 3E,11 with ack every cycle → one bundle: opcode=3E, len=1, imm=0011, pc=0000, cb=0; instr_valid first high 3 cycles after the first ack.
- Memory C3,12,34: with IMM_FIRST_HIGH=1 → imm=1234, len=2; with a second instance at IMM_FIRST_HIGH=0 → imm=3412.
- Memory CB,37,00 → bundle cb=1, opcode=37, len=0, pc=0000; next bundle opcode=00, pc=0002.
- instr_ready held 0 with immediate acks → fetch_req drops once occupancy reaches DEPTH; no byte lost; fetch_addr sequence is contiguous once ready is released.
- Flush with flush_pc=0x0100 in the middle of the FETCH_IMM of C3 and coincident with fetch_ack → partial bundle dropped, acked byte discarded, next fetch_addr=0100, next bundle pc=0100.
- nrst pulsed low while in PRESENT → all outputs 0 immediately (asynchronous), fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and opcode helpers for the instruction fetch front end.
// Assembler states, CB prefix byte and immediate-length lookup.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_CB,
    FETCH_IMM,
    PRESENT
  } asm_state;

  localparam logic [7:0] CB_PREFIX = 8'hCB;

  // CB-page opcodes never carry immediates, so 0xCB itself maps to 0.
  function automatic logic [1:0] imm_bytes(input logic [7:0] op);
    logic [1:0] n;
    n = 2'd0;
    case (op)
      8'h06, 8'h0E, 8'h16, 8'h1E,
      8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h18, 8'h20, 8'h28, 8'h30,
      8'h38, 8'hC6, 8'hCE, 8'hD6,
      8'hDE, 8'hE6, 8'hEE, 8'hF6,
      8'hFE, 8'hE0, 8'hF0, 8'hE8,
      8'hF8: n = 2'd1;
      8'h01, 8'h11, 8'h21, 8'h31,
      8'h08, 8'hC2, 8'hC3, 8'hC4,
      8'hCA, 8'hCC, 8'hCD, 8'hD2,
      8'hD4, 8'hDA, 8'hDC, 8'hEA,
      8'hFA: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH x 8 synchronous byte FIFO with clear.
// Registered read port: a pushed byte is visible the next cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [7:0]             data_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output logic [7:0]             data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = pop_i & ~empty_o & ~clear_i;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + PTR_W'(do_push);
      rd_q  <= rd_q + PTR_W'(do_pop);
      cnt_q <= cnt_q + CNT_W'(do_push)
                     - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_assembler.sv
// Prefetches the byte stream and assembles whole instructions
// (optional CB prefix, opcode, immediates) for the decoder.
module instr_fetch_assembler
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH          = 4,
  parameter int unsigned       ADDR_W         = 16,
  parameter bit                IMM_FIRST_HIGH = 1'b1,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0
) (
  input  logic              clk,
  input  logic              nrst,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  input  logic [7:0]        fetch_data,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic              instr_cb,
  output logic [15:0]       instr_imm,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  asm_state          state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rdpc_q, rdpc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        op_q, op_d;
  logic              cb_q, cb_d;
  logic [15:0]       imm_q, imm_d;
  logic [1:0]        len_q, len_d;
  logic              idx_q, idx_d;

  logic              push;
  logic              pop;
  logic              empty;
  logic              full;
  logic [7:0]        rd_byte;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              hi_slot;

  assign push = req_q & fetch_ack & ~flush & ~full;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (nrst),
    .push_i (push),
    .data_i (fetch_data),
    .pop_i  (pop),
    .clear_i(flush),
    .data_o (rd_byte),
    .empty_o(empty),
    .full_o (full),
    .count_o(count)
  );

  // Request only if the byte would still fit after this cycle settles.
  always_comb begin
    count_nxt = count + CNT_W'(push)
                      - CNT_W'(pop);
    req_d  = flush | (count_nxt < CNT_W'(DEPTH));
    addr_d = addr_q;
    rdpc_d = rdpc_q + ADDR_W'(pop);
    if (flush) begin
      addr_d = flush_pc;
      rdpc_d = flush_pc;
    end else if (push) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  assign hi_slot = (len_q == 2'd2)
                 & (idx_q ^ IMM_FIRST_HIGH);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cb_d    = cb_q;
    imm_d   = imm_q;
    len_d   = len_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = FETCH_OP;
      cb_d    = 1'b0;
      imm_d   = '0;
      len_d   = '0;
      idx_d   = 1'b0;
    end else begin
      unique case (state_q)
        FETCH_OP: begin
          if (!empty) begin
            pop   = 1'b1;
            pc_d  = rdpc_q;
            cb_d  = 1'b0;
            imm_d = '0;
            idx_d = 1'b0;
            if (rd_byte == CB_PREFIX) begin
              len_d   = '0;
              state_d = FETCH_CB;
            end else begin
              op_d  = rd_byte;
              len_d = imm_bytes(rd_byte);
              if (imm_bytes(rd_byte) == 2'd0) begin
                state_d = PRESENT;
              end else begin
                state_d = FETCH_IMM;
              end
            end
          end
        end
        FETCH_CB: begin
          if (!empty) begin
            pop     = 1'b1;
            op_d    = rd_byte;
            cb_d    = 1'b1;
            len_d   = '0;
            state_d = PRESENT;
          end
        end
        FETCH_IMM: begin
          if (!empty) begin
            pop   = 1'b1;
            idx_d = 1'b1;
            if (hi_slot) begin
              imm_d[15:8] = rd_byte;
            end else begin
              imm_d[7:0] = rd_byte;
            end
            if (len_q == 2'd1 || idx_q) begin
              state_d = PRESENT;
            end
          end
        end
        PRESENT: begin
          if (instr_ready) begin
            state_d = FETCH_OP;
          end
        end
        default: state_d = FETCH_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= FETCH_OP;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      rdpc_q  <= RESET_PC;
      pc_q    <= '0;
      op_q    <= '0;
      cb_q    <= 1'b0;
      imm_q   <= '0;
      len_q   <= '0;
      idx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      rdpc_q  <= rdpc_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      cb_q    <= cb_d;
      imm_q   <= imm_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  assign fetch_req    = req_q & ~flush;
  assign fetch_addr   = addr_q;
  assign instr_valid  = (state_q == PRESENT);
  assign instr_opcode = op_q;
  assign instr_cb     = cb_q;
  assign instr_imm    = imm_q;
  assign instr_len    = len_q;
  assign instr_pc     = pc_q;

endmodule

// File: tb/tb_instr_fetch_assembler.sv
// Bench for instr_fetch_assembler: two instances (both immediate
// byte orders) against a byte-stream instruction parser model.
module tb_instr_fetch_assembler;

  localparam int          DEPTH = 4;
  localparam logic [15:0] RPC   = 16'h0000;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] flush_pc = '0;
  logic        instr_ready = 1'b0;

  logic        req1, ack1 = 1'b0, valid1, cb1;
  logic [15:0] addr1, imm1, pc1;
  logic [7:0]  data1 = '0, op1;
  logic [1:0]  len1;

  logic        req0, ack0 = 1'b0, valid0, cb0;
  logic [15:0] addr0, imm0, pc0;
  logic [7:0]  data0 = '0, op0;
  logic [1:0]  len0;

  logic [7:0]  mem [0:65535];
  int          ack_pct = 0;
  int          rdy_pct = 0;
  int          vecs = 0;
  int          errs = 0;
  int          hs1 = 0;
  int          hs0 = 0;
  logic [15:0] exp1, exp0;

  logic [7:0] one_b [25] = '{
    8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
    8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE, 8'hD6,
    8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0, 8'hE8,
    8'hF8};
  logic [7:0] two_b [17] = '{
    8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hC4,
    8'hCA, 8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA,
    8'hFA};

  always #5 clk = ~clk;

  instr_fetch_assembler #(
    .DEPTH(DEPTH), .ADDR_W(16),
    .IMM_FIRST_HIGH(1'b1), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .nrst(nrst),
    .fetch_req(req1), .fetch_addr(addr1),
    .fetch_ack(ack1), .fetch_data(data1),
    .flush(flush), .flush_pc(flush_pc),
    .instr_valid(valid1), .instr_ready(instr_ready),
    .instr_opcode(op1), .instr_cb(cb1),
    .instr_imm(imm1), .instr_len(len1), .instr_pc(pc1)
  );

  instr_fetch_assembler #(
    .DEPTH(DEPTH), .ADDR_W(16),
    .IMM_FIRST_HIGH(1'b0), .RESET_PC(RPC)
  ) dut_le (
    .clk(clk), .nrst(nrst),
    .fetch_req(req0), .fetch_addr(addr0),
    .fetch_ack(ack0), .fetch_data(data0),
    .flush(flush), .flush_pc(flush_pc),
    .instr_valid(valid0), .instr_ready(instr_ready),
    .instr_opcode(op0), .instr_cb(cb0),
    .instr_imm(imm0), .instr_len(len0), .instr_pc(pc0)
  );

  function automatic int imm_len(input logic [7:0] b);
    foreach (one_b[i]) if (one_b[i] == b) return 1;
    foreach (two_b[i]) if (two_b[i] == b) return 2;
    return 0;
  endfunction

  // bundle = {cb, opcode, len, imm, pc}
  function automatic void model(
    input  logic [15:0] pc,
    input  bit          hi,
    output logic [42:0] bun,
    output logic [15:0] nxt);
    logic [7:0] b0, b1, b2;
    int n;
    b0 = mem[pc];
    b1 = mem[pc + 16'd1];
    b2 = mem[pc + 16'd2];
    if (b0 == 8'hCB) begin
      bun = {1'b1, b1, 2'd0, 16'h0000, pc};
      nxt = pc + 16'd2;
    end else begin
      n = imm_len(b0);
      if (n == 0)
        bun = {1'b0, b0, 2'd0, 16'h0000, pc};
      else if (n == 1)
        bun = {1'b0, b0, 2'd1, 8'h00, b1, pc};
      else if (hi)
        bun = {1'b0, b0, 2'd2, b1, b2, pc};
      else
        bun = {1'b0, b0, 2'd2, b2, b1, pc};
      nxt = pc + 16'(1 + n);
    end
  endfunction

  // memory and decoder-side drivers
  initial begin
    forever begin
      @(negedge clk);
      #1;
      ack1 = ($urandom_range(0, 99) < ack_pct);
      ack0 = ($urandom_range(0, 99) < ack_pct);
      instr_ready = ($urandom_range(0, 99) < rdy_pct);
      data1 = mem[addr1];
      data0 = mem[addr0];
    end
  end

  // scoreboard: every accepted bundle is the next parsed instruction
  initial begin
    logic [42:0] want, got;
    logic [15:0] nxt;
    exp1 = RPC;
    exp0 = RPC;
    forever begin
      @(negedge clk);
      #2;
      if (!nrst) begin
        exp1 = RPC;
        exp0 = RPC;
      end else if (flush) begin
        exp1 = flush_pc;
        exp0 = flush_pc;
      end else if (instr_ready) begin
        if (valid1) begin
          model(exp1, 1'b1, want, nxt);
          got = {cb1, op1, len1, imm1, pc1};
          vecs++;
          if (got !== want) begin
            errs++;
            $display("FAIL bundle_hi got=%h want=%h", got, want);
          end
          exp1 = nxt;
          hs1++;
        end
        if (valid0) begin
          model(exp0, 1'b0, want, nxt);
          got = {cb0, op0, len0, imm0, pc0};
          vecs++;
          if (got !== want) begin
            errs++;
            $display("FAIL bundle_lo got=%h want=%h", got, want);
          end
          exp0 = nxt;
          hs0++;
        end
      end
    end
  end

  task automatic hold_reset();
    @(negedge clk);
    ack_pct = 0;
    rdy_pct = 0;
    flush = 1'b0;
    nrst = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill(input int base, input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) mem[16'(base + i)] = v;
  endtask

  task automatic test_reset();
    hold_reset();
    #3;
    vecs++;
    if ({req1, addr1, valid1, op1, cb1, imm1, len1, pc1} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got=%h want=0",
        {req1, addr1, valid1, op1, cb1, imm1, len1, pc1});
    end
    release_reset();
    #3;
    vecs++;
    if ({req1, addr1} !== {1'b1, RPC}) begin
      errs++;
      $display("FAIL req_after_reset got=%h want=%h",
        {req1, addr1}, {1'b1, RPC});
    end
  endtask

  task automatic test_latency();
    int k;
    hold_reset();
    fill(0, 16, 8'h00);
    mem[0] = 8'h3E;
    mem[1] = 8'h11;
    release_reset();
    ack_pct = 100;
    rdy_pct = 100;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      #3;
      if (valid1) k = i;
    end
    vecs++;
    if (k !== 3) begin
      errs++;
      $display("FAIL latency got=%0d want=3", k);
    end
    vecs++;
    if ({cb1, op1, len1, imm1, pc1} !==
        {1'b0, 8'h3E, 2'd1, 16'h0011, 16'h0000}) begin
      errs++;
      $display("FAIL first_bundle got=%h want=%h",
        {cb1, op1, len1, imm1, pc1},
        {1'b0, 8'h3E, 2'd1, 16'h0011, 16'h0000});
    end
  endtask

  task automatic test_imm_order();
    logic [25:0] g1, g0;
    bit s1, s0;
    hold_reset();
    fill(0, 16, 8'h00);
    mem[0] = 8'hC3;
    mem[1] = 8'h12;
    mem[2] = 8'h34;
    release_reset();
    ack_pct = 100;
    rdy_pct = 100;
    g1 = '0; g0 = '0; s1 = 0; s0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (valid1 && !s1) begin s1 = 1; g1 = {op1, len1, imm1}; end
      if (valid0 && !s0) begin s0 = 1; g0 = {op0, len0, imm0}; end
    end
    vecs++;
    if (g1 !== {8'hC3, 2'd2, 16'h1234}) begin
      errs++;
      $display("FAIL imm_high_first got=%h want=%h", g1,
        {8'hC3, 2'd2, 16'h1234});
    end
    vecs++;
    if (g0 !== {8'hC3, 2'd2, 16'h3412}) begin
      errs++;
      $display("FAIL imm_low_first got=%h want=%h", g0,
        {8'hC3, 2'd2, 16'h3412});
    end
  endtask

  task automatic test_cb();
    logic [42:0] b [2];
    int n;
    hold_reset();
    fill(0, 16, 8'h00);
    mem[0] = 8'hCB;
    mem[1] = 8'h37;
    release_reset();
    ack_pct = 100;
    rdy_pct = 100;
    n = 0;
    b[0] = '0;
    b[1] = '0;
    for (int i = 0; i < 30 && n < 2; i++) begin
      @(negedge clk);
      #3;
      if (valid1 && instr_ready) begin
        b[n] = {cb1, op1, len1, imm1, pc1};
        n++;
      end
    end
    vecs++;
    if (b[0] !== {1'b1, 8'h37, 2'd0, 16'h0, 16'h0000}) begin
      errs++;
      $display("FAIL cb_bundle got=%h", b[0]);
    end
    vecs++;
    if (b[1] !== {1'b0, 8'h00, 2'd0, 16'h0, 16'h0002}) begin
      errs++;
      $display("FAIL after_cb got=%h", b[1]);
    end
  endtask

  task automatic test_backpressure();
    int n;
    hold_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i);
    release_reset();
    ack_pct = 100;
    rdy_pct = 0;
    repeat (20) @(negedge clk);
    #3;
    vecs++;
    if ({req1, addr1} !== {1'b0, 16'(1 + DEPTH)}) begin
      errs++;
      $display("FAIL fifo_full_stall got=%h want=%h",
        {req1, addr1}, {1'b0, 16'(1 + DEPTH)});
    end
    vecs++;
    if ({valid1, op1} !== {1'b1, 8'h40}) begin
      errs++;
      $display("FAIL held_bundle got=%h want=%h",
        {valid1, op1}, {1'b1, 8'h40});
    end
    rdy_pct = 100;
    n = 0;
    for (int i = 0; i < 40 && n < 8; i++) begin
      @(negedge clk);
      #3;
      if (valid1 && instr_ready) begin
        vecs++;
        if ({op1, pc1} !== {8'(8'h40 + n), 16'(n)}) begin
          errs++;
          $display("FAIL stream_order got=%h want=%h",
            {op1, pc1}, {8'(8'h40 + n), 16'(n)});
        end
        n++;
      end
    end
    vecs++;
    if (n !== 8) begin
      errs++;
      $display("FAIL stream_count got=%0d want=8", n);
    end
  endtask

  task automatic test_flush();
    bit s;
    hold_reset();
    fill(0, 16, 8'h00);
    fill(16'h0100, 16, 8'h00);
    mem[0] = 8'hC3;
    mem[1] = 8'h12;
    mem[2] = 8'h34;
    mem[16'h0100] = 8'h06;
    mem[16'h0101] = 8'hAB;
    release_reset();
    ack_pct = 100;
    rdy_pct = 100;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    flush_pc = 16'h0100;
    #3;
    vecs++;
    if (req1 !== 1'b0) begin
      errs++;
      $display("FAIL req_in_flush got=%b want=0", req1);
    end
    @(negedge clk);
    flush = 1'b0;
    #3;
    vecs++;
    if ({valid1, addr1} !== {1'b0, 16'h0100}) begin
      errs++;
      $display("FAIL after_flush got=%h want=%h",
        {valid1, addr1}, {1'b0, 16'h0100});
    end
    s = 0;
    for (int i = 0; i < 20 && !s; i++) begin
      @(negedge clk);
      #3;
      if (valid1 && instr_ready) begin
        s = 1;
        vecs++;
        if ({cb1, op1, len1, imm1, pc1} !==
            {1'b0, 8'h06, 2'd1, 16'h00AB, 16'h0100}) begin
          errs++;
          $display("FAIL flush_target got=%h",
            {cb1, op1, len1, imm1, pc1});
        end
      end
    end
    vecs++;
    if (!s) begin
      errs++;
      $display("FAIL flush_target_timeout got=none want=bundle");
    end
  endtask

  task automatic test_async_reset();
    hold_reset();
    fill(0, 16, 8'h00);
    release_reset();
    ack_pct = 100;
    rdy_pct = 0;
    repeat (5) @(negedge clk);
    #3;
    vecs++;
    if (valid1 !== 1'b1) begin
      errs++;
      $display("FAIL present_before_reset got=%b want=1", valid1);
    end
    nrst = 1'b0;
    ack_pct = 0;
    #1;
    vecs++;
    if ({req1, addr1, valid1, op1, cb1, imm1, len1, pc1} !== '0) begin
      errs++;
      $display("FAIL async_reset got=%h want=0",
        {req1, addr1, valid1, op1, cb1, imm1, len1, pc1});
    end
    release_reset();
    #3;
    vecs++;
    if ({req1, addr1} !== {1'b1, RPC}) begin
      errs++;
      $display("FAIL restart got=%h want=%h",
        {req1, addr1}, {1'b1, RPC});
    end
  endtask

  task automatic test_random();
    int b1, b0;
    hold_reset();
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    release_reset();
    b1 = hs1;
    b0 = hs0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i % 200 == 0) begin
        ack_pct = $urandom_range(30, 100);
        rdy_pct = $urandom_range(30, 100);
      end
      if (flush)
        flush = 1'b0;
      else if ($urandom_range(0, 99) < 2) begin
        flush = 1'b1;
        flush_pc = 16'($urandom);
      end
    end
    @(negedge clk);
    flush = 1'b0;
    rdy_pct = 0;
    vecs++;
    if (hs1 - b1 < 100 || hs0 - b0 < 100) begin
      errs++;
      $display("FAIL random_progress got=%0d/%0d want>=100",
        hs1 - b1, hs0 - b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_latency();
    test_imm_order();
    test_cb();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
